// File: rtl/pulse_bram_reader_if.sv
// Stream and BRAM port bundle for pulse_bram_reader.
// The master side is the reader; the slave side is the consumer plus the BRAM.
interface pulse_bram_reader_if;
    logic [31:0] out_data;
    logic [10:0] out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] bram_addr;
    logic [31:0] bram_data_in;
    logic [31:0] bram_data_out;
    logic        ena;
    logic        bram_we;

    modport master (
        output out_data, out_index, out_valid, out_last,
        output bram_addr, bram_data_in, ena, bram_we,
        input  out_ready, bram_data_out
    );

    modport slave (
        input  out_data, out_index, out_valid, out_last,
        input  bram_addr, bram_data_in, ena, bram_we,
        output out_ready, bram_data_out
    );
endinterface

// File: rtl/pulse_bram_reader.sv
// Sweeps a pulse-accumulation BRAM once per frame, streams each word out with a
// valid/ready handshake, optionally zeroes it behind itself and counts nonzero words.
module pulse_bram_reader #(
    parameter int DEPTH     = 2048,
    parameter int ADDR_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clear_en,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [31:0]         nonzero_count,
    pulse_bram_reader_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, OUT, CLR, DONE} state_t;

    localparam logic [10:0] LAST_INDEX = 11'(DEPTH - 1);
    localparam logic [31:0] STEP       = 32'(ADDR_STEP);

    state_t      state, state_next;
    logic [10:0] index, index_next;
    logic        clear_lat, clear_lat_next;
    logic [31:0] nonzero_next;
    logic [31:0] out_data_q, out_data_next;
    logic [10:0] out_index_q, out_index_next;
    logic        out_valid_q, out_valid_next;
    logic        out_last_q, out_last_next;
    logic [31:0] addr_q, addr_next;
    logic        ena_q, ena_next;
    logic        we_q, we_next;
    logic        busy_next, done_next;
    logic        advance;

    // Every output is a register loaded with the value that belongs to the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            clear_lat     <= 1'b0;
            nonzero_count <= '0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            addr_q        <= '0;
            ena_q         <= 1'b0;
            we_q          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            index         <= index_next;
            clear_lat     <= clear_lat_next;
            nonzero_count <= nonzero_next;
            out_data_q    <= out_data_next;
            out_index_q   <= out_index_next;
            out_valid_q   <= out_valid_next;
            out_last_q    <= out_last_next;
            addr_q        <= addr_next;
            ena_q         <= ena_next;
            we_q          <= we_next;
            busy          <= busy_next;
            done          <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        index_next     = index;
        clear_lat_next = clear_lat;
        nonzero_next   = nonzero_count;
        out_data_next  = out_data_q;
        out_index_next = out_index_q;
        out_valid_next = out_valid_q;
        out_last_next  = out_last_q;
        addr_next      = addr_q;
        ena_next       = 1'b0;
        we_next        = 1'b0;
        busy_next      = busy;
        done_next      = 1'b0;
        advance        = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next     = RD_REQ;
                    index_next     = '0;
                    clear_lat_next = clear_en;
                    nonzero_next   = '0;
                    addr_next      = '0;
                    ena_next       = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            RD_REQ: state_next = RD_WAIT;
            RD_WAIT: begin
                state_next     = OUT;
                out_data_next  = bus.bram_data_out;
                out_index_next = index;
                out_last_next  = (index == LAST_INDEX);
                out_valid_next = 1'b1;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    // The sign bit is ignored so that -0.0 is counted as zero.
                    nonzero_next   = nonzero_count + {31'd0, |out_data_q[30:0]};
                    if (clear_lat) begin
                        state_next = CLR;
                        ena_next   = 1'b1;
                        we_next    = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            CLR:  advance = 1'b1;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (index == LAST_INDEX) begin
                state_next = DONE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
            end else begin
                index_next = index + 11'd1;
                state_next = RD_REQ;
                ena_next   = 1'b1;
                addr_next  = 32'(index_next) * STEP;
            end
        end

        // Abort discards whatever the current state had scheduled, including a count update.
        if (abort && state != IDLE) begin
            state_next     = IDLE;
            ena_next       = 1'b0;
            we_next        = 1'b0;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b0;
            nonzero_next   = nonzero_count;
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.bram_addr    = addr_q;
    assign bus.bram_data_in = '0;
    assign bus.ena          = ena_q;
    assign bus.bram_we      = we_q;

endmodule

// File: tb/tb_pulse_bram_reader.sv
// Directed bench for pulse_bram_reader with an 8-word registered BRAM model.
module tb_pulse_bram_reader;
    localparam int DEPTH     = 8;
    localparam int ADDR_STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clear_en;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] nonzero_count;

    pulse_bram_reader_if bus();

    pulse_bram_reader #(.DEPTH(DEPTH), .ADDR_STEP(ADDR_STEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clear_en      (clear_en),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .nonzero_count (nonzero_count),
        .bus           (bus)
    );

    logic [31:0] pre [8] = '{32'h3F800000, 32'h00000000, 32'h3DA339C1, 32'h80000000,
                             32'h00000000, 32'h3F59AD43, 32'h00000000, 32'h3B83126F};
    logic [31:0] mem [8];
    logic        load_req = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int start_cycle = 0;
    int done_cycle = 0;
    int done_count = 0;
    int we_count = 0;

    logic [31:0] q_data [$];
    logic [10:0] q_index [$];
    logic        q_last [$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Registered-read BRAM: read data appears one edge after an ena=1, we=0 cycle.
    always @(posedge clk) begin
        if (load_req) begin
            mem <= pre;
        end else if (bus.ena) begin
            if (bus.bram_we) mem[bus.bram_addr[4:2]] <= bus.bram_data_in;
            else             bus.bram_data_out <= mem[bus.bram_addr[4:2]];
        end
    end

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_index.push_back(bus.out_index);
            q_last.push_back(bus.out_last);
        end
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        if (bus.bram_we) we_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic clr);
        @(posedge clk);
        #1;
        q_data.delete();
        q_index.delete();
        q_last.delete();
        we_count    = 0;
        clear_en    = clr;
        start       = 1'b1;
        start_cycle = cycle;
    endtask

    task loadBram();
        @(posedge clk);
        #1 load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task waitIdle(input string tag);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "_timeout"}, 32'(k < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task checkStream(input string tag, input int zero_below, input int skip);
        logic [31:0] exp_word;
        checkOutput({tag, "_count"}, 32'(q_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            exp_word = (i < zero_below) ? 32'd0 : pre[i];
            checkOutput({tag, "_index"}, 32'(q_index[i]), 32'(i));
            checkOutput({tag, "_last"}, 32'(q_last[i]), 32'(i == 7));
            if (i != skip) checkOutput({tag, "_data"}, q_data[i], exp_word);
        end
    endtask

    task checkMem(input string tag, input int lo, input int hi, input logic zeroed);
        for (int i = lo; i <= hi; i++)
            checkOutput({tag, "_word"}, mem[i], zeroed ? 32'd0 : pre[i]);
    endtask

    task checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        checkOutput({tag, "_out_data"}, bus.out_data, 32'd0);
        checkOutput({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
        checkOutput({tag, "_nonzero"}, nonzero_count, 32'd0);
        checkOutput({tag, "_bram_addr"}, bus.bram_addr, 32'd0);
        checkOutput({tag, "_bram_data_in"}, bus.bram_data_in, 32'd0);
        checkOutput({tag, "_ena"}, 32'(bus.ena), 32'd0);
        checkOutput({tag, "_bram_we"}, 32'(bus.bram_we), 32'd0);
    endtask

    initial begin
        int k;
        int stall_bad;
        int done_before;

        rst_n         = 1'b1;
        start         = 1'b0;
        clear_en      = 1'b0;
        abort         = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 checkResetValues("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        loadBram();

        $display("[TB] frame with clear_en=1");
        applyStimulus(1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("f1_busy_after_start", 32'(busy), 32'd1);
        waitIdle("f1");
        checkOutput("f1_latency", 32'(done_cycle - start_cycle + 1), 32'd34);
        checkOutput("f1_done_count", 32'(done_count), 32'd1);
        checkStream("f1", 0, -1);
        checkOutput("f1_nonzero", nonzero_count, 32'd4);
        checkMem("f1_cleared", 0, 7, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("f1_nonzero_held", nonzero_count, 32'd4);
        checkOutput("f1_done_low", 32'(done), 32'd0);

        $display("[TB] frame with clear_en=0");
        loadBram();
        applyStimulus(1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle("f2");
        checkOutput("f2_latency", 32'(done_cycle - start_cycle + 1), 32'd26);
        checkOutput("f2_done_count", 32'(done_count), 32'd2);
        checkStream("f2", 0, -1);
        checkOutput("f2_nonzero", nonzero_count, 32'd4);
        checkMem("f2_unchanged", 0, 7, 1'b0);
        checkOutput("f2_we_seen", 32'(we_count), 32'd0);

        $display("[TB] five-cycle stall at index 3");
        loadBram();
        applyStimulus(1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!(bus.out_valid && bus.out_index == 11'd3) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("stall_reach_index3", 32'(k < 100), 32'd1);
        bus.out_ready = 1'b0;
        stall_bad = 0;
        for (int s = 0; s < 6; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            if (!(bus.out_valid && bus.out_index == 11'd3 && bus.out_data == pre[3] && !bus.ena))
                stall_bad++;
        end
        bus.out_ready = 1'b1;
        checkOutput("stall_hold_bad_cycles", 32'(stall_bad), 32'd0);
        waitIdle("stall");
        checkOutput("stall_latency", 32'(done_cycle - start_cycle + 1), 32'd39);
        checkStream("stall", 0, -1);
        checkOutput("stall_nonzero", nonzero_count, 32'd4);
        checkMem("stall_cleared", 0, 7, 1'b1);

        $display("[TB] abort during index 4");
        loadBram();
        applyStimulus(1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!(bus.out_valid && bus.out_index == 11'd4) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("abort_reach_index4", 32'(k < 100), 32'd1);
        done_before = done_count;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_ena", 32'(bus.ena), 32'd0);
        checkOutput("abort_we", 32'(bus.bram_we), 32'd0);
        checkOutput("abort_nonzero", nonzero_count, 32'd2);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_count - done_before), 32'd0);
        checkOutput("abort_still_idle", 32'(busy), 32'd0);
        checkMem("abort_cleared", 0, 3, 1'b1);
        checkMem("abort_kept", 4, 7, 1'b0);

        $display("[TB] abort and start together in idle");
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", 32'(busy), 32'd0);
        checkOutput("abort_start_ena", 32'(bus.ena), 32'd0);
        checkOutput("abort_start_nonzero_kept", nonzero_count, 32'd2);

        $display("[TB] reset during clear of index 2");
        loadBram();
        applyStimulus(1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!(bus.bram_we && bus.bram_addr == 32'd8) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("rst_reach_clr2", 32'(k < 100), 32'd1);
        done_before = done_count;
        rst_n = 1'b0;
        #1 checkResetValues("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_resume_busy", 32'(busy), 32'd0);
        checkOutput("rst_no_resume_ena", 32'(bus.ena), 32'd0);
        checkOutput("rst_no_done", 32'(done_count - done_before), 32'd0);
        checkMem("rst_cleared", 0, 1, 1'b1);
        checkMem("rst_kept", 3, 7, 1'b0);
        applyStimulus(1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle("rerun");
        checkOutput("rerun_latency", 32'(done_cycle - start_cycle + 1), 32'd26);
        checkStream("rerun", 2, 2);

        $display("[TB] start held while busy");
        loadBram();
        done_before = done_count;
        applyStimulus(1'b0);
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        waitIdle("hold");
        checkOutput("hold_latency", 32'(done_cycle - start_cycle + 1), 32'd26);
        checkStream("hold", 0, -1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_single_done", 32'(done_count - done_before), 32'd1);
        checkOutput("hold_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
